// File: rtl/dbank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dbank_sched                                                  |
// | Description : Ping-pong scheduler for a double-buffered data bank. One     |
// |               bank (selected by o_cbank) is the compute bank used by the   |
// |               array; the other is the host bank, loaded and drained by     |
// |               the external port. Once the compute run has finished and the |
// |               host bank is loaded, the banks are swapped and a start pulse |
// |               is sent to the array. Host accesses to the compute bank are  |
// |               masked and reported.                                         |
// | Ports       : clk, rst_n      clock, synchronous active-low reset          |
// |               i_en           scheduling enable (0 keeps FSM in IDLE)      |
// |               i_flush        abort to IDLE, drop host-loaded flag         |
// |               i_ld_done      pulse: host bank loaded                      |
// |               i_run_done     pulse: array finished on compute bank        |
// |               i_exsel/i_exwe/i_exre  host bank select, write, read         |
// |               o_cbank        compute bank select                          |
// |               o_run_start    1-cycle array start                          |
// |               o_ld_req       host bank free to load                       |
// |               o_exwe/o_exre  gated host write/read                        |
// |               o_busy         FSM not idle                                 |
// |               o_ex_err       pulse: blocked access or rejected load       |
// |               o_seq_err      pulse: run_done outside RUN                  |
// |               o_swap_cnt     completed swaps (wraps)                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dbank_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_ld_done,
    input  logic             i_run_done,
    input  logic             i_exsel,
    input  logic             i_exwe,
    input  logic             i_exre,
    output logic             o_cbank,
    output logic             o_run_start,
    output logic             o_ld_req,
    output logic             o_exwe,
    output logic             o_exre,
    output logic             o_busy,
    output logic             o_ex_err,
    output logic             o_seq_err,
    output logic [CNT_W-1:0] o_swap_cnt
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWAP  = 2'd1;
    localparam logic [1:0] c_ST_START = 2'd2;
    localparam logic [1:0] c_ST_RUN   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_cbank;
    logic             r_host_full;
    logic [CNT_W-1:0] r_swap_cnt;
    logic             r_ex_err;
    logic             r_seq_err;

    logic             w_in_swap;
    logic             w_ld_req;
    logic             w_acc_ld;
    logic             w_ld_rej;
    logic             w_ex_ok;
    logic             w_ex_blk;
    logic             w_want_swap;

    // The bank select flips at the end of SWAP, so host traffic and loads are
    // held off for that one cycle to avoid landing on the wrong bank.
    assign w_in_swap   = (r_state == c_ST_SWAP);
    assign w_ld_req    = ~r_host_full & ~w_in_swap;
    assign w_acc_ld    = i_ld_done & w_ld_req;
    assign w_ld_rej    = i_ld_done & ~w_ld_req;
    assign w_ex_ok     = (i_exsel != r_cbank) & ~w_in_swap;
    assign w_ex_blk    = (i_exwe | i_exre) & ~w_ex_ok;
    // A load accepted this very cycle counts, so IDLE/RUN can swap without
    // waiting a cycle for the flag to register.
    assign w_want_swap = i_en & (r_host_full | w_acc_ld);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_want_swap) w_state_nxt = c_ST_SWAP;
            c_ST_SWAP:  w_state_nxt = c_ST_START;
            c_ST_START: w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (i_run_done) w_state_nxt = w_want_swap ? c_ST_SWAP : c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        if (i_flush) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cbank     <= 1'b0;
            r_host_full <= 1'b0;
            r_swap_cnt  <= '0;
            r_ex_err    <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (i_flush || w_in_swap) begin
                r_host_full <= 1'b0;
            end else if (w_acc_ld) begin
                r_host_full <= 1'b1;
            end

            // A flush landing on SWAP cancels the swap itself.
            if (w_in_swap && !i_flush) begin
                r_cbank    <= ~r_cbank;
                r_swap_cnt <= r_swap_cnt + c_CNT_ONE;
            end

            r_ex_err  <= w_ld_rej | w_ex_blk;
            r_seq_err <= i_run_done & (r_state != c_ST_RUN);
        end
    end

    assign o_cbank     = r_cbank;
    assign o_run_start = (r_state == c_ST_START);
    assign o_ld_req    = w_ld_req;
    assign o_exwe      = i_exwe & w_ex_ok;
    assign o_exre      = i_exre & w_ex_ok;
    assign o_busy      = (r_state != c_ST_IDLE);
    assign o_ex_err    = r_ex_err;
    assign o_seq_err   = r_seq_err;
    assign o_swap_cnt  = r_swap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dbank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dbank_sched                                               |
// | Description : Self-checking bench for dbank_sched. Directed scenarios then |
// |               randomized traffic, all compared cycle by cycle against a    |
// |               behavioural model of the ping-pong schedule.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dbank_sched;

    localparam int CNT_W   = 2;
    localparam int CNT_MOD = 4;

    logic             clk;
    logic             rst_n;
    logic             i_en, i_flush, i_ld_done, i_run_done;
    logic             i_exsel, i_exwe, i_exre;
    logic             o_cbank, o_run_start, o_ld_req, o_exwe, o_exre;
    logic             o_busy, o_ex_err, o_seq_err;
    logic [CNT_W-1:0] o_swap_cnt;

    int n_checks;
    int n_fails;

    // Model of the schedule: which step of the swap sequence we are in,
    // which bank computes, whether the host bank holds fresh data.
    string m_phase;
    int    m_cbank;
    int    m_full;
    int    m_swaps;
    int    m_ex_err;
    int    m_seq_err;

    dbank_sched #(.CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_flush    (i_flush),
        .i_ld_done  (i_ld_done),
        .i_run_done (i_run_done),
        .i_exsel    (i_exsel),
        .i_exwe     (i_exwe),
        .i_exre     (i_exre),
        .o_cbank    (o_cbank),
        .o_run_start(o_run_start),
        .o_ld_req   (o_ld_req),
        .o_exwe     (o_exwe),
        .o_exre     (o_exre),
        .o_busy     (o_busy),
        .o_ex_err   (o_ex_err),
        .o_seq_err  (o_seq_err),
        .o_swap_cnt (o_swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = "IDLE";
        m_cbank   = 0;
        m_full    = 0;
        m_swaps   = 0;
        m_ex_err  = 0;
        m_seq_err = 0;
    endtask

    // One clock cycle: drive inputs mid-cycle, compare every output with the
    // model, then advance the model across the rising edge.
    task automatic step(input bit rstn, input bit en, input bit flush, input bit ld,
                        input bit run, input bit sel, input bit we, input bit re);
        bit ld_free, access_ok, loaded, go_swap;
        @(negedge clk);
        rst_n = rstn; i_en = en; i_flush = flush; i_ld_done = ld; i_run_done = run;
        i_exsel = sel; i_exwe = we; i_exre = re;
        #1;
        ld_free   = (m_full == 0) && (m_phase != "SWAP");
        access_ok = (int'(sel) != m_cbank) && (m_phase != "SWAP");
        check("cbank",     int'(o_cbank),     m_cbank);
        check("run_start", int'(o_run_start), int'(m_phase == "START"));
        check("ld_req",    int'(o_ld_req),    int'(ld_free));
        check("exwe",      int'(o_exwe),      int'(we && access_ok));
        check("exre",      int'(o_exre),      int'(re && access_ok));
        check("busy",      int'(o_busy),      int'(m_phase != "IDLE"));
        check("ex_err",    int'(o_ex_err),    m_ex_err);
        check("seq_err",   int'(o_seq_err),   m_seq_err);
        check("swap_cnt",  int'(o_swap_cnt),  m_swaps);

        if (!rstn) begin
            model_reset();
        end else begin
            loaded    = ld && ld_free;
            go_swap   = en && ((m_full != 0) || loaded);
            m_ex_err  = int'((ld && !ld_free) || ((we || re) && !access_ok));
            m_seq_err = int'(run && (m_phase != "RUN"));
            if (flush) begin
                m_full  = 0;
                m_phase = "IDLE";
            end else if (m_phase == "SWAP") begin
                m_cbank = 1 - m_cbank;
                m_swaps = (m_swaps + 1) % CNT_MOD;
                m_full  = 0;
                m_phase = "START";
            end else begin
                if (loaded) m_full = 1;
                if (m_phase == "START")                  m_phase = "RUN";
                else if (m_phase == "IDLE" && go_swap)   m_phase = "SWAP";
                else if (m_phase == "RUN" && run)        m_phase = go_swap ? "SWAP" : "IDLE";
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_cyc(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_reset();
        rst_n = 1'b0; i_en = 1'b0; i_flush = 1'b0; i_ld_done = 1'b0;
        i_run_done = 1'b0; i_exsel = 1'b0; i_exwe = 1'b0; i_exre = 1'b0;

        // Reset, then first load from IDLE: SWAP next, toggle + start after.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_ld_req", int'(o_ld_req), 1);
        check("rst_cbank",  int'(o_cbank), 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        #2;
        check("t1_swap_busy",  int'(o_busy), 1);
        check("t1_swap_ldreq", int'(o_ld_req), 0);
        check("t1_swap_start", int'(o_run_start), 0);
        idle_cyc(1);
        #2;
        check("t1_cbank", int'(o_cbank), 1);
        check("t1_start", int'(o_run_start), 1);
        check("t1_cnt",   int'(o_swap_cnt), 1);
        idle_cyc(1);

        // Load during RUN, run_done 5 cycles later swaps straight away.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle_cyc(4);
        step(1, 1, 0, 0, 1, 0, 0, 0);
        idle_cyc(1);
        #2;
        check("t2_cbank", int'(o_cbank), 0);
        check("t2_start", int'(o_run_start), 1);
        check("t2_cnt",   int'(o_swap_cnt), 2);
        idle_cyc(1);

        // Simultaneous load and run_done: third swap, cbank back to 1.
        step(1, 1, 0, 1, 1, 0, 0, 0);
        idle_cyc(2);
        #2;
        check("t2b_cbank", int'(o_cbank), 1);
        check("t2b_cnt",   int'(o_swap_cnt), 3);

        // Host write to the compute bank is blocked; host bank passes.
        step(1, 1, 0, 0, 0, 1, 1, 0);
        #2;
        check("t3_blk_we",  int'(o_exwe), 0);
        check("t3_blk_err", int'(o_ex_err), 1);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        #2;
        check("t3_ok_we",  int'(o_exwe), 1);
        check("t3_ok_err", int'(o_ex_err), 0);

        // Second load without a swap is rejected.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        #2;
        check("t4_rej_err",  int'(o_ex_err), 1);
        check("t4_rej_busy", int'(o_busy), 1);
        check("t4_ld_req",   int'(o_ld_req), 0);

        // Flush in RUN with host loaded.
        step(1, 1, 1, 0, 0, 0, 0, 0);
        #2;
        check("t5_busy",   int'(o_busy), 0);
        check("t5_ld_req", int'(o_ld_req), 1);
        check("t5_cbank",  int'(o_cbank), 1);
        check("t5_start",  int'(o_run_start), 0);
        idle_cyc(2);
        #2;
        check("t5_stay_idle", int'(o_busy), 0);

        // run_done in IDLE, then the fourth swap wraps the 2-bit counter.
        step(1, 1, 0, 0, 1, 0, 0, 0);
        #2;
        check("t6_seq_err", int'(o_seq_err), 1);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle_cyc(2);
        #2;
        check("t6_wrap", int'(o_swap_cnt), 0);
        check("t6_cbank", int'(o_cbank), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
